// File: rtl/xram_arb_if.sv
// Bundle of requester-side and XRAM-side signals around the XRAM arbiter.
interface xram_arb_if #(
   parameter int unsigned NREQ = 3
);
   // requester side, flattened per requester
   logic [NREQ-1:0]    req_stb;
   logic [NREQ-1:0]    req_wr;
   logic [NREQ-1:0]    req_lock;
   logic [16*NREQ-1:0] req_addr;
   logic [8*NREQ-1:0]  req_data_out;
   logic [NREQ-1:0]    req_ack;
   logic [7:0]         req_data_in;
   // XRAM side
   logic [15:0]        xram_addr;
   logic [7:0]         xram_data_out;
   logic               xram_wr;
   logic               xram_stb;
   logic [7:0]         xram_data_in;
   logic               xram_ack;
   // status
   logic [NREQ-1:0]    grant;
   logic               timeout_err;
   logic [1:0]         err_req;

   // arbiter view
   modport slave (
      input  req_stb, req_wr, req_lock, req_addr, req_data_out, xram_data_in, xram_ack,
      output req_ack, req_data_in, xram_addr, xram_data_out, xram_wr, xram_stb,
             grant, timeout_err, err_req
   );

   // engines + XRAM view
   modport master (
      output req_stb, req_wr, req_lock, req_addr, req_data_out, xram_data_in, xram_ack,
      input  req_ack, req_data_in, xram_addr, xram_data_out, xram_wr, xram_stb,
             grant, timeout_err, err_req
   );
endinterface

// File: rtl/xram_arb.sv
// Round-robin arbiter for the single XRAM port, with burst lock and ack watchdog.
module xram_arb #(
   parameter int unsigned NREQ      = 3,
   parameter int unsigned MAX_BURST = 16,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic      clk,
   input  logic      rst,
   xram_arb_if.slave bus
);
   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned BW = $clog2(MAX_BURST + 1);
   localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
   logic [BW-1:0]   burst_cnt_q, burst_cnt_d;
   logic [WW-1:0]   wdog_q, wdog_d;
   logic            timeout_err_q, timeout_err_d;
   logic [1:0]      err_req_q, err_req_d;

   logic [NREQ:0][15:0]   addr_acc;
   logic [NREQ:0][7:0]    dout_acc;
   logic [NREQ:0]         wr_acc;
   logic [NREQ:0][PW-1:0] gidx_acc;
   logic [PW-1:0]         g_idx_c;
   logic [PW-1:0]         next_ptr_c;
   logic                  stb_c;
   logic                  lock_c;

   // First set bit of reqs searching upward from ptr, modulo NREQ (rotate, isolate lowest, rotate back).
   function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] reqs,
                                               input logic [PW-1:0]   ptr);
      logic [2*NREQ-1:0] dbl;
      logic [NREQ-1:0]   rot;
      logic [NREQ-1:0]   low;
      dbl = {reqs, reqs} >> ptr;
      rot = dbl[NREQ-1:0];
      low = rot & (~rot + NREQ'(1));
      dbl = {low, low} << ptr;
      return dbl[2*NREQ-1:NREQ];
   endfunction

   // One-hot grant steers the granted requester onto the XRAM bus and yields its index.
   assign addr_acc[0] = '0;
   assign dout_acc[0] = '0;
   assign wr_acc[0]   = 1'b0;
   assign gidx_acc[0] = '0;
   for (genvar i = 0; i < NREQ; i++) begin : g_mux
      assign addr_acc[i+1] = addr_acc[i] | (grant_q[i] ? bus.req_addr[16*i +: 16] : 16'h0);
      assign dout_acc[i+1] = dout_acc[i] | (grant_q[i] ? bus.req_data_out[8*i +: 8] : 8'h0);
      assign wr_acc[i+1]   = wr_acc[i] | (grant_q[i] & bus.req_wr[i]);
      assign gidx_acc[i+1] = gidx_acc[i] | (grant_q[i] ? PW'(i) : PW'(0));
   end

   assign g_idx_c    = gidx_acc[NREQ];
   assign next_ptr_c = (32'(g_idx_c) == NREQ - 1) ? PW'(0) : g_idx_c + PW'(1);
   assign stb_c      = |(grant_q & bus.req_stb);
   assign lock_c     = |(grant_q & bus.req_lock);

   assign bus.xram_addr     = addr_acc[NREQ];
   assign bus.xram_data_out = dout_acc[NREQ];
   assign bus.xram_wr       = wr_acc[NREQ];
   assign bus.xram_stb      = stb_c;
   assign bus.req_ack       = grant_q & {NREQ{bus.xram_ack & stb_c}};
   assign bus.req_data_in   = bus.xram_data_in;
   assign bus.grant         = grant_q;
   assign bus.timeout_err   = timeout_err_q;
   assign bus.err_req       = err_req_q;

   // Next-state: arbitration, burst lock, release/rearbitration, abandon and watchdog.
   always_comb begin
      state_d       = state_q;
      grant_d       = grant_q;
      rr_ptr_d      = rr_ptr_q;
      burst_cnt_d   = burst_cnt_q;
      wdog_d        = wdog_q;
      timeout_err_d = timeout_err_q;
      err_req_d     = err_req_q;
      case (state_q)
         IDLE: begin
            burst_cnt_d = '0;
            wdog_d      = '0;
            if (|bus.req_stb) begin
               grant_d = rr_pick(bus.req_stb, rr_ptr_q);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (stb_c && bus.xram_ack) begin
               wdog_d = '0;
               if (lock_c && (32'(burst_cnt_q) + 32'd1 < MAX_BURST)) begin
                  burst_cnt_d = burst_cnt_q + BW'(1);
               end else begin
                  // release: the just-acked strobe is excluded so others win first
                  rr_ptr_d    = next_ptr_c;
                  burst_cnt_d = '0;
                  grant_d     = rr_pick(bus.req_stb & ~grant_q, next_ptr_c);
                  state_d     = (|(bus.req_stb & ~grant_q)) ? BUSY : IDLE;
               end
            end else if (!stb_c) begin
               // granted requester abandoned its transfer
               rr_ptr_d    = next_ptr_c;
               grant_d     = '0;
               burst_cnt_d = '0;
               wdog_d      = '0;
               state_d     = IDLE;
            end else if (32'(wdog_q) == TIMEOUT) begin
               timeout_err_d = 1'b1;
               err_req_d     = 2'(g_idx_c);
               rr_ptr_d      = next_ptr_c;
               grant_d       = '0;
               burst_cnt_d   = '0;
               wdog_d        = '0;
               state_d       = IDLE;
            end else begin
               wdog_d = wdog_q + WW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         rr_ptr_q      <= '0;
         burst_cnt_q   <= '0;
         wdog_q        <= '0;
         timeout_err_q <= 1'b0;
         err_req_q     <= 2'd0;
      end else begin
         state_q       <= state_d;
         grant_q       <= grant_d;
         rr_ptr_q      <= rr_ptr_d;
         burst_cnt_q   <= burst_cnt_d;
         wdog_q        <= wdog_d;
         timeout_err_q <= timeout_err_d;
         err_req_q     <= err_req_d;
      end
   end
endmodule

// File: tb/tb_xram_arb.sv
// Directed bench for xram_arb: default instance plus a MAX_BURST=4 instance on shared stimulus.
module tb_xram_arb;
   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_stb;
   logic [2:0]  req_wr;
   logic [2:0]  req_lock;
   logic [47:0] req_addr;
   logic [23:0] req_dout;
   logic [7:0]  xdin;
   logic        xack;
   int          checks   = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   xram_arb_if #(.NREQ(3)) ifm ();
   xram_arb_if #(.NREQ(3)) ifb ();

   assign ifm.req_stb      = req_stb;
   assign ifm.req_wr       = req_wr;
   assign ifm.req_lock     = req_lock;
   assign ifm.req_addr     = req_addr;
   assign ifm.req_data_out = req_dout;
   assign ifm.xram_data_in = xdin;
   assign ifm.xram_ack     = xack;
   assign ifb.req_stb      = req_stb;
   assign ifb.req_wr       = req_wr;
   assign ifb.req_lock     = req_lock;
   assign ifb.req_addr     = req_addr;
   assign ifb.req_data_out = req_dout;
   assign ifb.xram_data_in = xdin;
   assign ifb.xram_ack     = xack;

   xram_arb #(.NREQ(3), .MAX_BURST(16), .TIMEOUT(255)) dut  (.clk(clk), .rst(rst), .bus(ifm));
   xram_arb #(.NREQ(3), .MAX_BURST(4),  .TIMEOUT(255)) dut4 (.clk(clk), .rst(rst), .bus(ifb));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // inputs change and outputs are sampled 2 time units after the rising edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      req_stb  = '0;
      req_wr   = '0;
      req_lock = '0;
      req_addr = '0;
      req_dout = '0;
      xdin     = '0;
      xack     = 1'b0;
      do_reset();

      // reset state
      chk("rst_grant", 32'(ifm.grant), 32'h0);
      chk("rst_terr", 32'(ifm.timeout_err), 32'h0);
      chk("rst_ereq", 32'(ifm.err_req), 32'h0);
      chk("rst_stb", 32'(ifm.xram_stb), 32'h0);
      chk("rst_ack", 32'(ifm.req_ack), 32'h0);
      chk("rst_addr", 32'(ifm.xram_addr), 32'h0);

      // 1: single read by req0, XRAM acks in the second granted cycle
      req_stb           = 3'b001;
      req_addr[15:0]    = 16'h0100;
      tick();
      chk("t1_grant", 32'(ifm.grant), 32'h1);
      chk("t1_stb", 32'(ifm.xram_stb), 32'h1);
      chk("t1_addr", 32'(ifm.xram_addr), 32'h0100);
      chk("t1_noack", 32'(ifm.req_ack), 32'h0);
      tick();
      xack = 1'b1;
      xdin = 8'hA5;
      #1;
      chk("t1_ack", 32'(ifm.req_ack), 32'h1);
      chk("t1_rdata", 32'(ifm.req_data_in), 32'hA5);
      tick();
      req_stb = '0;
      xack    = 1'b0;
      #1;
      chk("t1_idle_grant", 32'(ifm.grant), 32'h0);
      chk("t1_idle_stb", 32'(ifm.xram_stb), 32'h0);

      // 2: all three requesting, single-byte acks rotate with no idle gap
      do_reset();
      req_addr[31:16] = 16'h2222;
      req_dout[15:8]  = 8'h5A;
      req_wr          = 3'b010;
      req_stb         = 3'b111;
      xack            = 1'b1;
      tick();
      chk("t2_g0", 32'(ifm.grant), 32'h1);
      chk("t2_ack0", 32'(ifm.req_ack), 32'h1);
      chk("t2_wr0", 32'(ifm.xram_wr), 32'h0);
      tick();
      chk("t2_g1", 32'(ifm.grant), 32'h2);
      chk("t2_ack1", 32'(ifm.req_ack), 32'h2);
      chk("t2_wr1", 32'(ifm.xram_wr), 32'h1);
      chk("t2_dout1", 32'(ifm.xram_data_out), 32'h5A);
      chk("t2_addr1", 32'(ifm.xram_addr), 32'h2222);
      tick();
      chk("t2_g2", 32'(ifm.grant), 32'h4);
      chk("t2_stb2", 32'(ifm.xram_stb), 32'h1);
      tick();
      chk("t2_g3", 32'(ifm.grant), 32'h1);
      req_stb = '0;
      req_wr  = '0;
      xack    = 1'b0;
      tick();
      chk("t2_idle", 32'(ifm.grant), 32'h0);

      // 3: req0 locked 10-byte burst while req1 waits; MAX_BURST=4 instance rotates after 4
      do_reset();
      req_stb  = 3'b011;
      req_lock = 3'b001;
      xack     = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         if (i == 9) req_lock = 3'b000;
         #1;
         chk($sformatf("t3_ack_%0d", i), 32'(ifm.req_ack), 32'h1);
         if (i < 5) chk($sformatf("t3_mb4_ack_%0d", i), 32'(ifb.req_ack), (i < 4) ? 32'h1 : 32'h2);
         tick();
      end
      chk("t3_rot_grant", 32'(ifm.grant), 32'h2);
      chk("t3_rot_ack", 32'(ifm.req_ack), 32'h2);
      req_stb  = '0;
      req_lock = '0;
      xack     = 1'b0;
      tick();
      chk("t3_idle", 32'(ifm.grant), 32'h0);

      // 4: req1 granted and never acked; watchdog aborts, req2 granted next
      do_reset();
      req_stb = 3'b110;
      tick();
      chk("t4_grant", 32'(ifm.grant), 32'h2);
      repeat (255) tick();
      chk("t4_pre_grant", 32'(ifm.grant), 32'h2);
      chk("t4_pre_terr", 32'(ifm.timeout_err), 32'h0);
      chk("t4_pre_ack", 32'(ifm.req_ack), 32'h0);
      tick();
      chk("t4_terr", 32'(ifm.timeout_err), 32'h1);
      chk("t4_ereq", 32'(ifm.err_req), 32'h1);
      chk("t4_grant0", 32'(ifm.grant), 32'h0);
      chk("t4_noack", 32'(ifm.req_ack), 32'h0);
      tick();
      chk("t4_next", 32'(ifm.grant), 32'h4);
      chk("t4_sticky", 32'(ifm.timeout_err), 32'h1);
      req_stb = '0;
      tick();

      // 6: reset in the middle of a locked burst
      req_stb  = 3'b001;
      req_lock = 3'b001;
      xack     = 1'b1;
      tick();
      tick();
      tick();
      chk("t6_pre_grant", 32'(ifm.grant), 32'h1);
      chk("t6_pre_terr", 32'(ifm.timeout_err), 32'h1);
      rst = 1'b1;
      tick();
      chk("t6_grant", 32'(ifm.grant), 32'h0);
      chk("t6_stb", 32'(ifm.xram_stb), 32'h0);
      chk("t6_terr", 32'(ifm.timeout_err), 32'h0);
      chk("t6_ereq", 32'(ifm.err_req), 32'h0);
      chk("t6_ack", 32'(ifm.req_ack), 32'h0);
      rst      = 1'b0;
      req_stb  = '0;
      req_lock = '0;
      xack     = 1'b0;
      tick();

      // 5: req2 abandons while granted (pointer first moved to 1 by a req0 transfer)
      do_reset();
      req_stb = 3'b001;
      xack    = 1'b1;
      tick();
      tick();
      req_stb = 3'b100;
      xack    = 1'b0;
      tick();
      chk("t5_grant", 32'(ifm.grant), 32'h4);
      req_stb = '0;
      xack    = 1'b1;
      #1;
      chk("t5_stb", 32'(ifm.xram_stb), 32'h0);
      chk("t5_noack", 32'(ifm.req_ack), 32'h0);
      tick();
      chk("t5_idle", 32'(ifm.grant), 32'h0);
      req_stb = 3'b011;
      xack    = 1'b0;
      tick();
      chk("t5_ptr0", 32'(ifm.grant), 32'h1);
      req_stb = '0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
